// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave with NUM_REGS word-addressed 32-bit registers. Register 0 is a read-only ID.
// Write address and data are accepted independently and committed together; one write and one read may be outstanding.
module axi4lite_slave_regfile #(
  parameter int                   ADDRWIDTH = 32,
  parameter int                   DATAWIDTH = 32,
  parameter int                   NUM_REGS  = 16,
  parameter logic [DATAWIDTH-1:0] ID_VALUE  = 32'h4158_4C31
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [ADDRWIDTH-1:0]          AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [DATAWIDTH-1:0]          WDATA,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [ADDRWIDTH-1:0]          ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [DATAWIDTH-1:0]          RDATA,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [NUM_REGS*DATAWIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]           wr_strobe_o
);

  localparam int IDXW = $clog2(NUM_REGS);

  function automatic logic in_range(input logic [ADDRWIDTH-1:0] a);
    return (a >> (IDXW + 2)) == '0;
  endfunction

  logic                 aw_held_q, w_held_q, bvalid_q, rvalid_q;
  logic [ADDRWIDTH-1:0] awaddr_q;
  logic [DATAWIDTH-1:0] wdata_q, rdata_q;
  logic [NUM_REGS-1:0]  strobe_q;
  logic [DATAWIDTH-1:0] regs_q [1:NUM_REGS-1];

  logic                 aw_hs, w_hs, ar_hs, commit_d, wr_ok_d;
  logic [ADDRWIDTH-1:0] waddr_d;
  logic [DATAWIDTH-1:0] wdata_d, rdata_d;
  logic [IDXW-1:0]      widx_d, ridx_d;
  logic                 unused_addr_lsbs;

  // Readies depend only on registered state so masters never see a VALID->READY loop.
  assign AWREADY = !ARESET && !aw_held_q && !bvalid_q;
  assign WREADY  = !ARESET && !w_held_q && !bvalid_q;
  assign ARREADY = !ARESET && !rvalid_q;

  assign aw_hs    = AWVALID && AWREADY;
  assign w_hs     = WVALID && WREADY;
  assign ar_hs    = ARVALID && ARREADY;
  assign commit_d = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign waddr_d  = aw_held_q ? awaddr_q : AWADDR;
  assign wdata_d  = w_held_q ? wdata_q : WDATA;
  assign widx_d   = waddr_d[IDXW+1:2];
  assign wr_ok_d  = in_range(waddr_d) && (widx_d != '0);
  assign ridx_d   = ARADDR[IDXW+1:2];

  assign unused_addr_lsbs = ^{waddr_d[1:0], ARADDR[1:0]};

  always_comb begin
    rdata_d = '0;
    if (in_range(ARADDR)) begin
      if (ridx_d == '0) rdata_d = ID_VALUE;
      else              rdata_d = regs_q[ridx_d];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      strobe_q  <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      strobe_q <= '0;
      if (bvalid_q && BREADY) bvalid_q <= 1'b0;
      if (commit_d) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        if (wr_ok_d) begin
          regs_q[widx_d]   <= wdata_d;
          strobe_q[widx_d] <= 1'b1;
        end
      end else begin
        if (aw_hs) aw_held_q <= 1'b1;
        if (w_hs)  w_held_q  <= 1'b1;
      end
      // Read path: RDATA captured at AR handshake, so a same-edge write is not visible.
      if (ar_hs) begin
        rdata_q  <= rdata_d;
        rvalid_q <= 1'b1;
      end else if (rvalid_q && RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) awaddr_q <= AWADDR;
    if (w_hs)  wdata_q  <= WDATA;
  end

  assign BVALID      = bvalid_q;
  assign RVALID      = rvalid_q;
  assign RDATA       = rdata_q;
  assign wr_strobe_o = strobe_q;

  assign regs_o[0 +: DATAWIDTH] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATAWIDTH +: DATAWIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Bench for axi4lite_slave_regfile: directed scenarios plus randomized traffic against a register-array model.
module tb_axi4lite_slave_regfile;

  localparam int          NR = 16;
  localparam logic [31:0] ID = 32'h4158_4C31;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [31:0]   AWADDR, WDATA, ARADDR;
  logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [31:0]   RDATA;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0] wr_strobe_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [NR];

  axi4lite_slave_regfile dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o), .wr_strobe_o(wr_strobe_o)
  );

  always #5 ACLK = ~ACLK;

  // Model: 16 words at byte addresses 0..63; anything at or above 64 is outside the bank.
  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a >= 64) return 32'h0;
    if (a / 4 == 0) return ID;
    return model[a / 4];
  endfunction

  function automatic logic [NR-1:0] m_strobe(input logic [31:0] a);
    if (a >= 64 || a / 4 == 0) return '0;
    return NR'(1) << (a / 4);
  endfunction

  function automatic logic [NR*32-1:0] m_vec();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = (i == 0) ? ID : model[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
    AWADDR = 0; WDATA = 0; ARADDR = 0;
  endtask

  // Full write with BREADY=1; returns the strobe seen in the BVALID cycle.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [NR-1:0] strb);
    bit aw_go, w_go, aw_done = 0, w_done = 0;
    int n = 0;
    strb = '0;
    AWADDR = a; WDATA = d; AWVALID = 1; WVALID = 1; BREADY = 1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_go = AWVALID && AWREADY;
      w_go  = WVALID && WREADY;
      tick();
      n++;
      if (aw_go) begin aw_done = 1; AWVALID = 0; end
      if (w_go)  begin w_done  = 1; WVALID  = 0; end
    end
    total++;
    if (!BVALID) begin
      bad++;
      $display("FAIL write_bvalid addr=%h got BVALID=%b need 1", a, BVALID);
    end
    strb = wr_strobe_o;
    if (a < 64 && a / 4 != 0) model[a / 4] = d;
    tick();
    AWVALID = 0; WVALID = 0; BREADY = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    bit go;
    int n = 0;
    bit done = 0;
    d = 'x;
    ARADDR = a; ARVALID = 1; RREADY = 1;
    while (!done && n < 20) begin
      go = ARREADY;
      tick();
      n++;
      if (go) begin done = 1; ARVALID = 0; end
    end
    total++;
    if (!RVALID) begin
      bad++;
      $display("FAIL read_rvalid addr=%h got RVALID=%b need 1", a, RVALID);
    end
    d = RDATA;
    tick();
    RREADY = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESET = 1;
    tick(); tick();
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      bad++; $display("FAIL reset_readies got %b need 000", {AWREADY, WREADY, ARREADY});
    end
    total++;
    if ({BVALID, RVALID} !== 2'b00) begin
      bad++; $display("FAIL reset_valids got %b need 00", {BVALID, RVALID});
    end
    total++;
    if (regs_o[3*32 +: 32] !== 32'h0 || wr_strobe_o !== '0) begin
      bad++; $display("FAIL reset_regs got reg3=%h strb=%h need 0/0", regs_o[3*32 +: 32], wr_strobe_o);
    end
    ARESET = 0;
    #1;
    total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      bad++; $display("FAIL release_readies got %b need 111", {AWREADY, WREADY, ARREADY});
    end
    for (int i = 0; i < NR; i++) model[i] = 0;
    tick();
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] rd;
    AWADDR = 32'h0C; WDATA = 32'hDEADBEEF; AWVALID = 1; WVALID = 1; BREADY = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    model[3] = 32'hDEADBEEF;
    total++;
    if (regs_o[3*32 +: 32] !== 32'hDEADBEEF || wr_strobe_o !== 16'h0008 || BVALID !== 1'b1) begin
      bad++; $display("FAIL same_cycle_commit got reg3=%h strb=%h b=%b need deadbeef/0008/1",
                      regs_o[3*32 +: 32], wr_strobe_o, BVALID);
    end
    tick();
    total++;
    if (BVALID !== 1'b0 || wr_strobe_o !== '0) begin
      bad++; $display("FAIL same_cycle_bclear got b=%b strb=%h need 0/0", BVALID, wr_strobe_o);
    end
    BREADY = 0;
    axi_read(32'h0C, rd);
    total++;
    if (rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL same_cycle_read got %h need deadbeef", rd);
    end
  endtask

  task automatic test_w_before_aw();
    BREADY = 0;
    WDATA = 32'h12345678; WVALID = 1;
    tick();
    WVALID = 0;
    total++;
    if (WREADY !== 1'b0 || AWREADY !== 1'b1 || BVALID !== 1'b0) begin
      bad++; $display("FAIL w_first_held got wr=%b awr=%b b=%b need 0/1/0", WREADY, AWREADY, BVALID);
    end
    tick(); tick();
    total++;
    if (regs_o[8*32 +: 32] !== 32'h0) begin
      bad++; $display("FAIL w_first_early got reg8=%h need 0", regs_o[8*32 +: 32]);
    end
    AWADDR = 32'h20; AWVALID = 1;
    tick();
    AWVALID = 0;
    model[8] = 32'h12345678;
    total++;
    if (regs_o[8*32 +: 32] !== 32'h12345678 || wr_strobe_o !== 16'h0100 || BVALID !== 1'b1) begin
      bad++; $display("FAIL w_first_commit got reg8=%h strb=%h b=%b need 12345678/0100/1",
                      regs_o[8*32 +: 32], wr_strobe_o, BVALID);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (BVALID !== 1'b1 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        bad++; $display("FAIL bresp_hold cyc=%0d got b=%b awr=%b wr=%b need 1/0/0", i, BVALID, AWREADY, WREADY);
      end
    end
    BREADY = 1;
    tick();
    BREADY = 0;
    total++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      bad++; $display("FAIL bresp_release got b=%b awr=%b wr=%b need 0/1/1", BVALID, AWREADY, WREADY);
    end
  endtask

  task automatic test_ro_and_oor();
    logic [NR-1:0] s;
    logic [31:0] rd;
    axi_write(32'h00, 32'hFFFFFFFF, s);
    total++;
    if (s !== '0 || regs_o !== m_vec()) begin
      bad++; $display("FAIL ro_write got strb=%h need 0 (regs vector compared)", s);
    end
    axi_write(32'h400, 32'hFFFFFFFF, s);
    total++;
    if (s !== '0 || regs_o !== m_vec()) begin
      bad++; $display("FAIL oor_write got strb=%h need 0 (regs vector compared)", s);
    end
    axi_read(32'h00, rd);
    total++;
    if (rd !== 32'h41584C31) begin
      bad++; $display("FAIL id_read got %h need 41584c31", rd);
    end
    axi_read(32'h400, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("FAIL oor_read got %h need 0", rd);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] rd;
    ARADDR = 32'h04; ARVALID = 1; RREADY = 0;
    AWADDR = 32'h04; WDATA = 32'hA5A5A5A5; AWVALID = 1; WVALID = 1; BREADY = 1;
    tick();
    ARVALID = 0; AWVALID = 0; WVALID = 0;
    model[1] = 32'hA5A5A5A5;
    total++;
    if (RVALID !== 1'b1 || RDATA !== 32'h0 || regs_o[1*32 +: 32] !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL rw_same_edge got rv=%b rd=%h reg1=%h need 1/0/a5a5a5a5", RVALID, RDATA, regs_o[1*32 +: 32]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (RVALID !== 1'b1 || RDATA !== 32'h0 || ARREADY !== 1'b0) begin
        bad++; $display("FAIL rdata_hold cyc=%0d got rv=%b rd=%h arr=%b need 1/0/0", i, RVALID, RDATA, ARREADY);
      end
    end
    BREADY = 0;
    RREADY = 1;
    tick();
    RREADY = 0;
    total++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      bad++; $display("FAIL rvalid_release got rv=%b arr=%b need 0/1", RVALID, ARREADY);
    end
    axi_read(32'h04, rd);
    total++;
    if (rd !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL rw_followup got %h need a5a5a5a5", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] s;
    AWADDR = 32'h14; AWVALID = 1;
    tick();
    AWVALID = 0;
    ARESET = 1;
    tick();
    ARESET = 0;
    for (int i = 0; i < NR; i++) model[i] = 0;
    // Data alone after reset must not pair with the discarded address.
    WDATA = 32'h55AA55AA; WVALID = 1;
    tick();
    WVALID = 0;
    total++;
    if (BVALID !== 1'b0 || regs_o[5*32 +: 32] !== 32'h0 || AWREADY !== 1'b1) begin
      bad++; $display("FAIL reset_aw_held got b=%b reg5=%h awr=%b need 0/0/1", BVALID, regs_o[5*32 +: 32], AWREADY);
    end
    AWADDR = 32'h18; AWVALID = 1; BREADY = 0;
    tick();
    AWVALID = 0;
    model[6] = 32'h55AA55AA;
    ARESET = 1;
    tick();
    ARESET = 0;
    for (int i = 0; i < NR; i++) model[i] = 0;
    total++;
    if (BVALID !== 1'b0 || regs_o !== m_vec()) begin
      bad++; $display("FAIL reset_bpending got b=%b reg6=%h need 0/0", BVALID, regs_o[6*32 +: 32]);
    end
    axi_write(32'h14, 32'hCAFEF00D, s);
    total++;
    if (s !== 16'h0020 || regs_o[5*32 +: 32] !== 32'hCAFEF00D) begin
      bad++; $display("FAIL post_reset_write got strb=%h reg5=%h need 0020/cafef00d", s, regs_o[5*32 +: 32]);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] s;
    logic [31:0] a, d, rd;
    for (int it = 0; it < 40; it++) begin
      a = ($urandom_range(0, 7) == 0) ? ($urandom_range(16, 1023) * 4) : ($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      d = $urandom;
      axi_write(a, d, s);
      total++;
      if (s !== m_strobe(a) || regs_o !== m_vec()) begin
        bad++; $display("FAIL rand_write it=%0d addr=%h got strb=%h need %h", it, a, s, m_strobe(a));
      end
      a = ($urandom_range(0, 7) == 0) ? ($urandom_range(16, 1023) * 4) : ($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      axi_read(a, rd);
      total++;
      if (rd !== m_read(a)) begin
        bad++; $display("FAIL rand_read it=%0d addr=%h got %h need %h", it, a, rd, m_read(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_ro_and_oor();
    test_read_during_write();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4lite_slave_regfile.md
Name: axi4lite_slave_regfile

Overview:
- AXI4-Lite slave endpoint.
- Connects to the slave side of the team's AXI4-Lite interface and consumes the master's write-address, write-data and read-address traffic.
- Implements a bank of NUM_REGS word-addressed 32-bit control/status registers, exposed to surrounding hardware as a flat vector plus per-register write strobes.
- Register 0 is a read-only ID register.

Parameters:
- ADDRWIDTH, 32, width of AWADDR/ARADDR
- DATAWIDTH, 32, width of WDATA/RDATA and each register
- NUM_REGS, 16, number of registers (power of 2, >=2)
- ID_VALUE, 32'h4158_4C31, constant returned by register 0

Ports:
- ACLK  in  1  system clock, all logic on rising edge
- ARESET  in  1  synchronous reset, active-high
- AWADDR  in  ADDRWIDTH  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  DATAWIDTH  write data
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  ADDRWIDTH  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  DATAWIDTH  read data
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- regs_o  out  NUM_REGS*DATAWIDTH  register contents; reg i at bits [i*DATAWIDTH +: DATAWIDTH]; slice 0 = ID_VALUE
- wr_strobe_o  out  NUM_REGS  one-cycle pulse, bit i set on the cycle after reg i is written

Behaviour:
- Reset (ARESET=1 at a clock edge): all registers 1..NUM_REGS-1 <= 0; aw_held, w_held, BVALID, RVALID, wr_strobe_o <= 0; RDATA <= 0.
- While ARESET is high: AWREADY, WREADY, ARREADY are forced to 0. Reset mid-transaction discards all held address/data and pending responses, with no register update.
- Address decode: idx = ADDR[$clog2(NUM_REGS)+1:2]. Bits [1:0] are ignored. Addresses with any bit above the idx field set are out of range.
- Write channel state: flags aw_held and w_held, plus captured addr/data registers.
  - AWREADY = !ARESET & !aw_held & !BVALID.
  - WREADY = !ARESET & !w_held & !BVALID.
  - Ready signals are derived only from registered state, with no combinational dependency on VALID inputs.
  - AW and W handshakes complete independently, in either order or the same cycle. Each sets its held flag and captures its payload.
- Write commit: in the cycle where the address is available (held or handshaking now) and the data is available (held or handshaking now), at the next edge:
  - target reg <= data, if in range and idx != 0;
  - wr_strobe_o[idx] <= 1 on the same condition;
  - BVALID <= 1; held flags cleared.
  - Out-of-range writes and writes to reg 0 are dropped but still receive BVALID.
- Write latency: with AW and W in cycle N, regs_o and BVALID update at the end of cycle N and are visible in N+1.
- BVALID holds until the BVALID&BREADY edge, then clears; AWREADY/WREADY reassert the following cycle. Only one write is outstanding at a time.
- wr_strobe_o is a single-cycle pulse; all bits are 0 otherwise.
- Read channel:
  - ARREADY = !ARESET & !RVALID.
  - On ARVALID&ARREADY: RDATA <= reg[idx] (ID_VALUE for idx 0; 0 if out of range) and RVALID <= 1 at the next edge.
  - RDATA is stable while RVALID&!RREADY.
  - RVALID clears on the RVALID&RREADY edge; the next read is accepted one cycle later (two-cycle minimum per read).
- Simultaneous read and write to the same register at the same edge: the read returns the pre-write value.
- Read and write paths are fully independent and may be active concurrently.

Test Plan:
- Reset then idle: ARESET=1 for 2 cycles → all readies 0, BVALID=RVALID=0, regs_o slice 3 = 0; after release AWREADY=WREADY=ARREADY=1.
- AW(0x0C) and W(0xDEADBEEF) in the same cycle with BREADY=1 → next cycle regs_o slice 3 = 0xDEADBEEF, wr_strobe_o=16'h0008, BVALID=1 for exactly one cycle; then read 0x0C → RDATA=0xDEADBEEF with RVALID.
- W(0x12345678) three cycles before AW(0x20) → WREADY drops after the W handshake; commit happens only after AW; reg 8 = 0x12345678; BREADY held low 4 cycles → BVALID stays 1, AWREADY/WREADY stay 0 until BREADY.
- Write 0xFFFFFFFF to 0x00 and to 0x400 → both get BVALID, wr_strobe_o stays 0, regs unchanged; read 0x00 → 0x41584C31; read 0x400 → 0.
- Read 0x04 with RREADY low 3 cycles while writing 0xA5A5A5A5 to 0x04 the cycle AR completes → RDATA holds the old value (0) stable until RREADY; a subsequent read returns 0xA5A5A5A5.
- ARESET asserted with aw_held=1 and BVALID pending → after reset no BVALID, the target register is unchanged, and a new write completes normally.
